// File: rtl/signal_player.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | signal_player                                                              |
// | Plays a pattern from an external synchronous ROM, holding each sample for  |
// | a programmable number of clock cycles. Optional looping: define the macro  |
// | SIGNAL_PLAYER_LOOP_EN.                                                     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module signal_player #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  stop_i,
  input  logic [15:0]           div_i,
  input  logic [ADDR_WIDTH-1:0] last_i,
`ifdef SIGNAL_PLAYER_LOOP_EN
  input  logic                  loop_i,
`endif
  output logic [ADDR_WIDTH-1:0] rom_addr_o,
  input  logic [DATA_WIDTH-1:0] rom_data_i,
  output logic [DATA_WIDTH-1:0] sig_o,
  output logic                  sample_o,
  output logic                  busy_o,
  output logic                  done_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRIME = 2'd1,
    S_PLAY  = 2'd2
  } state_t;

  localparam logic [15:0]           c_MIN_PERIOD = 16'd2;
  localparam logic [ADDR_WIDTH-1:0] c_ADDR_ONE   = ADDR_WIDTH'(1);

  state_t                r_state, w_state_nxt;
  logic [DATA_WIDTH-1:0] r_sig, w_sig_nxt;
  logic                  r_sample, w_sample_nxt;
  logic                  r_done, w_done_nxt;
  logic [15:0]           r_cnt, w_cnt_nxt;
  logic [15:0]           r_period, w_period_nxt;
  logic [ADDR_WIDTH-1:0] r_cur, w_cur_nxt;
  logic [ADDR_WIDTH-1:0] r_last, w_last_nxt;
  logic                  w_loop_en;
  logic                  w_tick;
  logic                  w_at_last;

`ifdef SIGNAL_PLAYER_LOOP_EN
  logic r_loop, w_loop_nxt;
  assign w_loop_en = r_loop;
`else
  assign w_loop_en = 1'b0;
`endif

  assign w_tick    = (r_cnt == (r_period - 16'd1));
  assign w_at_last = (r_cur == r_last);

  // Prefetch the word that the next tick will load, wrapping to 0 after the last.
  assign rom_addr_o = (r_state == S_PLAY) ? (w_at_last ? '0 : r_cur + c_ADDR_ONE) : '0;
  assign sig_o      = r_sig;
  assign sample_o   = r_sample;
  assign done_o     = r_done;
  assign busy_o     = (r_state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_sig    <= '0;
      r_sample <= 1'b0;
      r_done   <= 1'b0;
      r_cnt    <= '0;
      r_cur    <= '0;
      r_period <= c_MIN_PERIOD;
      r_last   <= '0;
`ifdef SIGNAL_PLAYER_LOOP_EN
      r_loop   <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_sig    <= w_sig_nxt;
      r_sample <= w_sample_nxt;
      r_done   <= w_done_nxt;
      r_cnt    <= w_cnt_nxt;
      r_cur    <= w_cur_nxt;
      r_period <= w_period_nxt;
      r_last   <= w_last_nxt;
`ifdef SIGNAL_PLAYER_LOOP_EN
      r_loop   <= w_loop_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_sig_nxt    = r_sig;
    w_sample_nxt = 1'b0;
    w_done_nxt   = 1'b0;
    w_cnt_nxt    = r_cnt;
    w_cur_nxt    = r_cur;
    w_period_nxt = r_period;
    w_last_nxt   = r_last;
`ifdef SIGNAL_PLAYER_LOOP_EN
    w_loop_nxt   = r_loop;
`endif
    case (r_state)
      S_IDLE: begin
        if (start_i && !stop_i) begin
          w_state_nxt  = S_PRIME;
          w_period_nxt = (div_i < c_MIN_PERIOD) ? c_MIN_PERIOD : div_i;
          w_last_nxt   = last_i;
          w_cnt_nxt    = '0;
          w_cur_nxt    = '0;
`ifdef SIGNAL_PLAYER_LOOP_EN
          w_loop_nxt   = loop_i;
`endif
        end
      end
      // Two cycles: one for the ROM to register address 0, one to capture word 0.
      S_PRIME: begin
        if (stop_i) begin
          w_state_nxt = S_IDLE;
          w_sig_nxt   = '0;
          w_cnt_nxt   = '0;
        end else if (r_cnt == 16'd1) begin
          w_state_nxt  = S_PLAY;
          w_sig_nxt    = rom_data_i;
          w_sample_nxt = 1'b1;
          w_cnt_nxt    = '0;
          w_cur_nxt    = '0;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      S_PLAY: begin
        if (stop_i) begin
          w_state_nxt = S_IDLE;
          w_sig_nxt   = '0;
          w_cnt_nxt   = '0;
          w_cur_nxt   = '0;
        end else if (w_tick) begin
          w_cnt_nxt = '0;
          if (!w_at_last) begin
            w_sig_nxt    = rom_data_i;
            w_cur_nxt    = r_cur + c_ADDR_ONE;
            w_sample_nxt = 1'b1;
          end else if (w_loop_en) begin
            w_sig_nxt    = rom_data_i;
            w_cur_nxt    = '0;
            w_sample_nxt = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
            w_sig_nxt   = '0;
            w_cur_nxt   = '0;
            w_done_nxt  = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_sig_nxt   = '0;
        w_cnt_nxt   = '0;
        w_cur_nxt   = '0;
      end
    endcase
  end

endmodule
`default_nettype wire
